// File: rtl/pc_fetch_if.sv
// pc_fetch_if: word-wide instruction-memory request/ready bus between the fetch stage
// (master) and instruction memory (slave).
interface pc_fetch_if;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memReady;
  logic [31:0] memData;

  modport master (
    output memReq,
    output memAddr,
    input  memReady,
    input  memData
  );

  modport slave (
    input  memReq,
    input  memAddr,
    output memReady,
    output memData
  );
endinterface

// File: rtl/pc_fetch.sv
// pc_fetch: IF stage -- program counter, memory handshake, stall skid buffer, redirect/squash.
// Optional misaligned-target trap is built when FETCH_ALIGN_CHECK_EN is defined.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branchFlag,
  input  logic [31:0] branchTarget,
  pc_fetch_if.master  mem,
  output logic [31:0] ifPC,
  output logic [31:0] ifInst,
  output logic        ifValid,
  output logic        excFlag
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] BUF  = 2'd2;

  logic [1:0]  state_r, state_s;
  logic        mem_req_r, mem_req_s;
  logic [31:0] mem_addr_r, mem_addr_s;
  logic [31:0] if_pc_r, if_pc_s;
  logic [31:0] if_inst_r, if_inst_s;
  logic        if_valid_r, if_valid_s;
  logic        exc_r, exc_s;
  logic [31:0] buf_pc_r, buf_pc_s;
  logic [31:0] buf_inst_r, buf_inst_s;
  logic        redir_pending_r, redir_pending_s;
  logic [31:0] redir_addr_r, redir_addr_s;
  logic        discard_r, discard_s;
  logic        squash_r, squash_s;

  logic        done_s;
  logic        free_s;
  logic        redir_s;
  logic [31:0] target_s;
  logic [31:0] seq_addr_s;
  logic [31:0] tgt_load_s;
  logic        misalign_s;

`ifdef FETCH_ALIGN_CHECK_EN
  assign tgt_load_s = branchTarget;
  assign misalign_s = redir_s & (target_s[1:0] != 2'b00);
`else
  assign tgt_load_s = branchTarget & 32'hFFFF_FFFC;
  assign misalign_s = 1'b0;
`endif

  // free_s marks an edge where no request stays outstanding, so a new one may be issued
  // Next-state computation for the whole fetch stage
  always_comb begin
    state_s         = state_r;
    mem_req_s       = mem_req_r;
    mem_addr_s      = mem_addr_r;
    if_pc_s         = if_pc_r;
    if_inst_s       = if_inst_r;
    if_valid_s      = if_valid_r;
    exc_s           = exc_r;
    buf_pc_s        = buf_pc_r;
    buf_inst_s      = buf_inst_r;
    redir_pending_s = redir_pending_r;
    redir_addr_s    = redir_addr_r;
    discard_s       = discard_r;
    squash_s        = squash_r;
    free_s          = 1'b0;
    seq_addr_s      = mem_addr_r;
    done_s          = mem_req_r & mem.memReady;
    redir_s         = branchFlag | redir_pending_r;
    target_s        = branchFlag ? tgt_load_s : redir_addr_r;

    if (branchFlag) begin
      redir_pending_s = 1'b1;
      redir_addr_s    = tgt_load_s;
      exc_s           = 1'b0;
    end else begin
      redir_pending_s = redir_pending_r;
    end

    if (!stall && (branchFlag || squash_r)) begin
      if_valid_s = 1'b0;
      if_inst_s  = 32'd0;
      squash_s   = 1'b0;
    end else if (branchFlag) begin
      squash_s = 1'b1;
    end else begin
      squash_s = squash_r;
    end

    case (state_r)
      IDLE: begin
        state_s = REQ;
        free_s  = 1'b1;
      end
      REQ: begin
        if (mem_req_r && !mem.memReady) begin
          discard_s = discard_r | branchFlag;
        end else if (done_s) begin
          discard_s = 1'b0;
          if (discard_r || branchFlag) begin
            free_s = 1'b1;
          end else if (stall) begin
            buf_pc_s   = mem_addr_r;
            buf_inst_s = mem.memData;
            state_s    = BUF;
            mem_req_s  = 1'b0;
          end else begin
            if_pc_s    = mem_addr_r;
            if_inst_s  = mem.memData;
            if_valid_s = 1'b1;
            seq_addr_s = mem_addr_r + 32'd4;
            free_s     = 1'b1;
          end
        end else begin
          free_s = 1'b1;
        end
      end
      BUF: begin
        if (branchFlag) begin
          state_s = REQ;
          free_s  = 1'b1;
        end else if (!stall) begin
          if_pc_s    = buf_pc_r;
          if_inst_s  = buf_inst_r;
          if_valid_s = 1'b1;
          seq_addr_s = buf_pc_r + 32'd4;
          state_s    = REQ;
          free_s     = 1'b1;
        end else begin
          state_s = BUF;
        end
      end
      default: begin
        state_s   = IDLE;
        mem_req_s = 1'b0;
      end
    endcase

    mem_addr_s = (free_s && redir_s) ? target_s : seq_addr_s;

    // Issue decision: trapped, held off by stall, rejected as misaligned, or issued
    if (free_s) begin
      if (exc_s) begin
        mem_req_s = 1'b0;
      end else if (stall) begin
        mem_req_s = 1'b0;
      end else if (misalign_s) begin
        mem_req_s       = 1'b0;
        exc_s           = 1'b1;
        if_pc_s         = target_s;
        if_inst_s       = 32'd0;
        if_valid_s      = 1'b0;
        redir_pending_s = 1'b0;
      end else begin
        mem_req_s       = 1'b1;
        redir_pending_s = 1'b0;
      end
    end else begin
      mem_req_s = mem_req_s;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r         <= IDLE;
      mem_req_r       <= 1'b0;
      mem_addr_r      <= RESET_PC;
      if_pc_r         <= 32'd0;
      if_inst_r       <= 32'd0;
      if_valid_r      <= 1'b0;
      exc_r           <= 1'b0;
      buf_pc_r        <= 32'd0;
      buf_inst_r      <= 32'd0;
      redir_pending_r <= 1'b0;
      redir_addr_r    <= 32'd0;
      discard_r       <= 1'b0;
      squash_r        <= 1'b0;
    end else begin
      state_r         <= state_s;
      mem_req_r       <= mem_req_s;
      mem_addr_r      <= mem_addr_s;
      if_pc_r         <= if_pc_s;
      if_inst_r       <= if_inst_s;
      if_valid_r      <= if_valid_s;
      exc_r           <= exc_s;
      buf_pc_r        <= buf_pc_s;
      buf_inst_r      <= buf_inst_s;
      redir_pending_r <= redir_pending_s;
      redir_addr_r    <= redir_addr_s;
      discard_r       <= discard_s;
      squash_r        <= squash_s;
    end
  end

  assign mem.memReq  = mem_req_r;
  assign mem.memAddr = mem_addr_r;
  assign ifPC        = if_pc_r;
  assign ifInst      = if_inst_r;
  assign ifValid     = if_valid_r;
  assign excFlag     = exc_r;

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed self-checking bench for pc_fetch; memory returns addr ^ 32'hA5A5_A5A5.
// Expectations for the misaligned-target step follow FETCH_ALIGN_CHECK_EN.
module tb_pc_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branchFlag;
  logic [31:0] branchTarget;
  logic [31:0] ifPC;
  logic [31:0] ifInst;
  logic        ifValid;
  logic        excFlag;
  int          checks = 0;
  int          failures = 0;

  pc_fetch_if bus ();

  pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branchFlag   (branchFlag),
    .branchTarget (branchTarget),
    .mem          (bus),
    .ifPC         (ifPC),
    .ifInst       (ifInst),
    .ifValid      (ifValid),
    .excFlag      (excFlag)
  );

  always #5 clk = ~clk;

  assign bus.memData = bus.memAddr ^ 32'hA5A5_A5A5;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hA5A5_A5A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input string tag, input logic [31:0] pc);
    chk({tag, "_pc"}, ifPC, pc);
    chk({tag, "_inst"}, ifInst, word(pc));
    chk({tag, "_valid"}, {31'd0, ifValid}, 32'd1);
  endtask

  initial begin
    rst = 1'b0;
    stall = 1'b0;
    branchFlag = 1'b0;
    branchTarget = 32'd0;
    bus.memReady = 1'b1;
    step();
    step();
    chk("rst_req", {31'd0, bus.memReq}, 32'd0);
    chk("rst_addr", bus.memAddr, 32'd0);
    chk("rst_pc", ifPC, 32'd0);
    chk("rst_inst", ifInst, 32'd0);
    chk("rst_valid", {31'd0, ifValid}, 32'd0);
    chk("rst_exc", {31'd0, excFlag}, 32'd0);
    rst = 1'b1;

    // Zero-wait streaming from reset
    step();
    chk("first_req", {31'd0, bus.memReq}, 32'd1);
    chk("first_addr", bus.memAddr, 32'd0);
    chk("first_valid", {31'd0, ifValid}, 32'd0);
    step();
    present("s0", 32'd0);
    chk("s0_addr", bus.memAddr, 32'd4);
    step();
    present("s4", 32'd4);
    chk("s4_addr", bus.memAddr, 32'd8);

    // Memory wait states at address 8
    bus.memReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_addr", bus.memAddr, 32'd8);
      chk("wait_req", {31'd0, bus.memReq}, 32'd1);
      chk("wait_pc", ifPC, 32'd4);
    end
    bus.memReady = 1'b1;
    step();
    present("s8", 32'd8);
    chk("s8_addr", bus.memAddr, 32'd12);

    // Stall while address 12 is outstanding; response lands in the skid buffer
    stall = 1'b1;
    bus.memReady = 1'b0;
    step();
    chk("stall_out_addr", bus.memAddr, 32'd12);
    chk("stall_out_req", {31'd0, bus.memReq}, 32'd1);
    bus.memReady = 1'b1;
    step();
    chk("buf_req", {31'd0, bus.memReq}, 32'd0);
    chk("buf_pc", ifPC, 32'd8);
    chk("buf_valid", {31'd0, ifValid}, 32'd1);
    step();
    chk("buf_hold_pc", ifPC, 32'd8);
    chk("buf_hold_req", {31'd0, bus.memReq}, 32'd0);
    stall = 1'b0;
    step();
    present("s12", 32'd12);
    chk("s12_addr", bus.memAddr, 32'd16);
    chk("s12_req", {31'd0, bus.memReq}, 32'd1);
    step();
    present("s16", 32'd16);
    chk("s16_addr", bus.memAddr, 32'd20);

    // Redirect to 0x100 while 20 is outstanding
    branchFlag = 1'b1;
    branchTarget = 32'h0000_0100;
    step();
    branchFlag = 1'b0;
    chk("br_bubble_valid", {31'd0, ifValid}, 32'd0);
    chk("br_bubble_inst", ifInst, 32'd0);
    chk("br_bubble_pc", ifPC, 32'd16);
    chk("br_addr", bus.memAddr, 32'h0000_0100);
    step();
    present("t100", 32'h0000_0100);
    chk("t100_addr", bus.memAddr, 32'h0000_0104);

    // Redirect under stall: no squash until stall drops
    branchFlag = 1'b1;
    branchTarget = 32'h0000_0200;
    stall = 1'b1;
    step();
    branchFlag = 1'b0;
    chk("bs_valid", {31'd0, ifValid}, 32'd1);
    chk("bs_pc", ifPC, 32'h0000_0100);
    chk("bs_req", {31'd0, bus.memReq}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("bs_hold_valid", {31'd0, ifValid}, 32'd1);
      chk("bs_hold_pc", ifPC, 32'h0000_0100);
    end
    stall = 1'b0;
    step();
    chk("bs_squash_valid", {31'd0, ifValid}, 32'd0);
    chk("bs_squash_inst", ifInst, 32'd0);
    chk("bs_issue_req", {31'd0, bus.memReq}, 32'd1);
    chk("bs_issue_addr", bus.memAddr, 32'h0000_0200);
    step();
    present("t200", 32'h0000_0200);

    // Misaligned target 0x102
    branchFlag = 1'b1;
    branchTarget = 32'h0000_0102;
    step();
    branchFlag = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis_exc", {31'd0, excFlag}, 32'd1);
    chk("mis_req", {31'd0, bus.memReq}, 32'd0);
    chk("mis_pc", ifPC, 32'h0000_0102);
    chk("mis_valid", {31'd0, ifValid}, 32'd0);
    step();
    chk("mis_hold_exc", {31'd0, excFlag}, 32'd1);
    chk("mis_hold_req", {31'd0, bus.memReq}, 32'd0);
`else
    chk("mis_exc", {31'd0, excFlag}, 32'd0);
    chk("mis_req", {31'd0, bus.memReq}, 32'd1);
    chk("mis_addr", bus.memAddr, 32'h0000_0100);
    step();
    present("mis_t100", 32'h0000_0100);
`endif
    branchFlag = 1'b1;
    branchTarget = 32'h0000_0300;
    step();
    branchFlag = 1'b0;
    chk("t300_exc", {31'd0, excFlag}, 32'd0);
    chk("t300_req", {31'd0, bus.memReq}, 32'd1);
    chk("t300_addr", bus.memAddr, 32'h0000_0300);
    chk("t300_bubble", {31'd0, ifValid}, 32'd0);
    step();
    present("t300", 32'h0000_0300);

    // Address wrap at the top of the space
    branchFlag = 1'b1;
    branchTarget = 32'hFFFF_FFFC;
    step();
    branchFlag = 1'b0;
    chk("wrap_addr", bus.memAddr, 32'hFFFF_FFFC);
    step();
    present("wrap_top", 32'hFFFF_FFFC);
    chk("wrap_next_addr", bus.memAddr, 32'd0);
    step();
    present("wrap_zero", 32'd0);
    chk("wrap_after_addr", bus.memAddr, 32'd4);

    // Asynchronous reset in the middle of an outstanding request
    bus.memReady = 1'b0;
    step();
    chk("mid_req", {31'd0, bus.memReq}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_req", {31'd0, bus.memReq}, 32'd0);
    chk("arst_addr", bus.memAddr, 32'd0);
    chk("arst_valid", {31'd0, ifValid}, 32'd0);
    chk("arst_pc", ifPC, 32'd0);
    step();
    rst = 1'b1;
    bus.memReady = 1'b1;
    step();
    chk("rel_req", {31'd0, bus.memReq}, 32'd1);
    chk("rel_addr", bus.memAddr, 32'd0);
    step();
    present("rel_s0", 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
